multpoly_ctrl: RTL and testbench
================================

Name: multpoly_ctrl

Overview:
- Moore FSM that sequences the Multpoly_DP schoolbook polynomial-multiplication datapath by driving its select lines R1..R16.
- One run:
  - clears the 2N-1 product coefficients;
  - accumulates c[i+j] += a[i]*b[j] for all i, j < N;
  - scans down from the top coefficient to latch the product length into deg.
- Sits between the SNTRUP757 top-level sequencer (start/done) and Multpoly_DP plus its coefficient memories.

Parameters:
N, 757, coefficients per operand; product holds 2N-1 coefficients.
MEM_LAT, 1, coefficient-memory read latency in cycles (1..3).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a multiplication; sampled only in IDLE
i  in  10  datapath outer counter
j  in  10  datapath inner counter
k  in  11  datapath clear counter
mem_address_o  in  11  datapath product read address
mem_output  in  26  product memory read data
R1..R16  out  1 each  datapath select lines (16 individual ports)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
Datapath encodings the FSM relies on:
- i (R1,R2), j (R3,R4), k (R8,R9): R_hold=1 -> hold; 0,1 -> increment; 0,0 -> clear.
- mem_input (R12,R13): 1,x -> hold; 0,1 -> mem_output + a*b; 0,0 -> zero.
- mem_address_o: R16=1 -> decrement; else R5=1 -> hold; else i+j.
- Address selects:
  - R10=0 -> oa<=i; R11=0 -> ob<=j.
  - mem_address_i: R6=0,R7=1 -> i+j; R6=0,R7=0 -> k.
- R15=0 -> deg<=mem_address_o+1.
- R14 is registered into write_enable, so the write occurs one cycle later.

Hold code: R1=R3=R5=R6=R8=R10=R11=R12=R15=1 and all other R lines 0. Every state drives the hold code except for the lines listed for it. All outputs are decoded from the state register only.

Reset:
- State IDLE.
- Hold code driven, so R14=0 and the datapath write_enable is 0 one cycle later.
- busy=0, done=0, wait counter 0.
- Reset mid-run aborts without further writes; the product memory contents are then undefined.

States:
- IDLE: on start go to CLR_INIT.
- CLR_INIT: R8=0,R9=0; R12=0,R13=0 (mem_input<=0). Go to CLR_WR.
- CLR_WR: R6=0,R7=0 (address_i<=k); R14=1. Go to CLR_INC.
- CLR_INC: if k==2N-2, go to MUL_INIT; else R8=0,R9=1 and go to CLR_WR.
- MUL_INIT: R1=0,R2=0; R3=0,R4=0. Go to M_ADDR.
- M_ADDR: R10=0, R11=0, R5=0, R6=0,R7=1. Go to M_WAIT.
- M_WAIT: hold for MEM_LAT cycles on an internal counter, then go to M_MAC.
- M_MAC: R12=0,R13=1. Go to M_WR.
- M_WR: R14=1. Go to M_NEXT.
- M_NEXT:
  - if j<N-1: R3=0,R4=1, go to M_ADDR;
  - else if i<N-1: R3=0,R4=0, R1=0,R2=1, go to M_ADDR;
  - else go to DEG_INIT.
- DEG_INIT: R5=0 (address_o <= i+j = 2N-2). Go to D_WAIT.
- D_WAIT: MEM_LAT cycles, then go to D_CHK.
- D_CHK:
  - if mem_output==0 and mem_address_o!=0: R16=1, go to D_WAIT;
  - else R15=0, go to DONE.
- DONE: done=1 for this cycle only. Go to IDLE.

Rules:
- start is ignored while busy; start held high re-triggers from IDLE.
- The write issued in M_WR lands during M_NEXT using the old address_i. The next M_ADDR reads a different c index, so there is no read-after-write hazard.
- All-zero product: the scan stops at address 0 and deg=1.
- Latency from start to done: 1 + 2(2N-1) + 1 + N^2(MEM_LAT+4) + 1 + S(MEM_LAT+1) + 1 cycles, where S = number of addresses read in the scan.
  - For N=757, MEM_LAT=1 the multiply phase is 2,865,245 cycles.

Test Plan:
- Reset, then idle 10 cycles -> hold code on R1..R16, busy=0, done=0, R14 never 1.
- Clear phase: N=4, MEM_LAT=1, start -> exactly 7 R14 pulses with address_i=0..6, mem_input=0.
- Multiply: N=4, a=[1,2,0,0], b=[3,0,0,5] -> c=[3,6,0,5,10,0,0], deg=5, one done pulse. done arrives exactly at the cycle given by the latency formula with S=3.
- Zero operand: N=4, a=0 -> all c=0, scan reaches address 0, deg=1, done asserted.
- MEM_LAT=3 with N=4 and the same operands -> identical c and deg; multiply phase is 16*7 cycles.
- Reset asserted in M_MAC -> next cycle IDLE with hold code; no write_enable after the following cycle. A new start then completes correctly.

Source files
------------

// File: rtl/multpoly_ctrl_if.sv
// rtl/multpoly_ctrl_if.sv - start/busy/done handshake between the top-level sequencer and multpoly_ctrl
interface multpoly_ctrl_if;
  logic start;
  logic busy;
  logic done;

  modport master (output start, input busy, input done);
  modport slave  (input start, output busy, output done);
endinterface

// File: rtl/multpoly_ctrl.sv
// rtl/multpoly_ctrl.sv - sequencer driving the Multpoly_DP select lines for schoolbook polynomial multiply
module multpoly_ctrl #(
  parameter int N       = 757,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  multpoly_ctrl_if.slave    host,
  input  logic [9:0]        i,
  input  logic [9:0]        j,
  input  logic [10:0]       k,
  input  logic [10:0]       mem_address_o,
  input  logic [25:0]       mem_output,
  output logic              R1,
  output logic              R2,
  output logic              R3,
  output logic              R4,
  output logic              R5,
  output logic              R6,
  output logic              R7,
  output logic              R8,
  output logic              R9,
  output logic              R10,
  output logic              R11,
  output logic              R12,
  output logic              R13,
  output logic              R14,
  output logic              R15,
  output logic              R16
);

  typedef enum logic [3:0] {
    IDLE, CLR_INIT, CLR_WR, CLR_INC, MUL_INIT, M_ADDR, M_WAIT, M_MAC,
    M_WR, M_NEXT, DEG_INIT, D_WAIT, D_CHK, DONE
  } state_t;

  // Bit n of this vector is select line Rn; every counter and register holds.
  localparam logic [16:1] HOLD   = 16'h4EB5;
  localparam logic [10:0] K_LAST = 11'(2 * N - 2);
  localparam logic [9:0]  N_LAST = 10'(N - 1);
  localparam logic [1:0]  W_LAST = 2'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt;
  logic        wait_last;
  logic        scan_more;
  logic [16:1] r;

  assign wait_last = (wait_cnt == W_LAST);
  assign scan_more = (mem_output == 26'd0) && (mem_address_o != 11'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if ((state == M_WAIT || state == D_WAIT) && !wait_last)
        wait_cnt <= wait_cnt + 2'd1;
      else
        wait_cnt <= 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (host.start) state_nxt = CLR_INIT;
      CLR_INIT: state_nxt = CLR_WR;
      CLR_WR:   state_nxt = CLR_INC;
      CLR_INC:  state_nxt = (k == K_LAST) ? MUL_INIT : CLR_WR;
      MUL_INIT: state_nxt = M_ADDR;
      M_ADDR:   state_nxt = M_WAIT;
      M_WAIT:   if (wait_last) state_nxt = M_MAC;
      M_MAC:    state_nxt = M_WR;
      M_WR:     state_nxt = M_NEXT;
      M_NEXT:   state_nxt = (j < N_LAST || i < N_LAST) ? M_ADDR : DEG_INIT;
      DEG_INIT: state_nxt = D_WAIT;
      D_WAIT:   if (wait_last) state_nxt = D_CHK;
      D_CHK:    state_nxt = scan_more ? D_WAIT : DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Branching states qualify their select lines with the datapath status they branch on.
  always_comb begin
    r = HOLD;
    case (state)
      CLR_INIT: begin r[8] = 1'b0; r[9] = 1'b0; r[12] = 1'b0; r[13] = 1'b0; end
      CLR_WR:   begin r[6] = 1'b0; r[7] = 1'b0; r[14] = 1'b1; end
      CLR_INC:  if (k != K_LAST) begin r[8] = 1'b0; r[9] = 1'b1; end
      MUL_INIT: begin r[1] = 1'b0; r[2] = 1'b0; r[3] = 1'b0; r[4] = 1'b0; end
      M_ADDR:   begin
        r[10] = 1'b0; r[11] = 1'b0; r[5] = 1'b0; r[6] = 1'b0; r[7] = 1'b1;
      end
      M_MAC:    begin r[12] = 1'b0; r[13] = 1'b1; end
      M_WR:     r[14] = 1'b1;
      M_NEXT:   begin
        if (j < N_LAST) begin
          r[3] = 1'b0; r[4] = 1'b1;
        end else if (i < N_LAST) begin
          r[3] = 1'b0; r[4] = 1'b0; r[1] = 1'b0; r[2] = 1'b1;
        end
      end
      DEG_INIT: r[5] = 1'b0;
      D_CHK:    if (scan_more) r[16] = 1'b1; else r[15] = 1'b0;
      default:  r = HOLD;
    endcase
  end

  assign host.busy = (state != IDLE);
  assign host.done = (state == DONE);

  assign R1  = r[1];
  assign R2  = r[2];
  assign R3  = r[3];
  assign R4  = r[4];
  assign R5  = r[5];
  assign R6  = r[6];
  assign R7  = r[7];
  assign R8  = r[8];
  assign R9  = r[9];
  assign R10 = r[10];
  assign R11 = r[11];
  assign R12 = r[12];
  assign R13 = r[13];
  assign R14 = r[14];
  assign R15 = r[15];
  assign R16 = r[16];

endmodule

// File: tb/tb_multpoly_ctrl.sv
// tb/tb_multpoly_ctrl.sv - bench for multpoly_ctrl with a Multpoly_DP behavioural model, MEM_LAT 1 and 3
module tb_multpoly_ctrl;
  localparam int TN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [16:1] rl      [2];
  logic [25:0] mo      [2];

  logic [9:0]  i_r [2], j_r [2], oa_r [2], ob_r [2];
  logic [10:0] k_r [2], ao_r [2], ai_r [2], deg_r [2];
  logic [25:0] min_r [2];
  logic        we_r  [2];
  logic [25:0] c_mem [2][7];
  logic [25:0] pipe  [2][3];
  logic [25:0] a_mem [2][TN];
  logic [25:0] b_mem [2][TN];

  for (genvar g = 0; g < 2; g++) begin : gi
    multpoly_ctrl_if hif ();
    logic [16:1] r;
    assign hif.start = start_v[g];
    assign busy_v[g] = hif.busy;
    assign done_v[g] = hif.done;
    assign rl[g]     = r;
    multpoly_ctrl #(.N(TN), .MEM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst), .host(hif),
      .i(i_r[g]), .j(j_r[g]), .k(k_r[g]),
      .mem_address_o(ao_r[g]), .mem_output(mo[g]),
      .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]), .R6(r[6]),
      .R7(r[7]), .R8(r[8]), .R9(r[9]), .R10(r[10]), .R11(r[11]), .R12(r[12]),
      .R13(r[13]), .R14(r[14]), .R15(r[15]), .R16(r[16])
    );
  end

  always_comb begin
    mo[0] = pipe[0][0];
    mo[1] = pipe[1][2];
  end

  // Multpoly_DP behavioural model; product memory reads are MEM_LAT stages deep.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rl[g][1]) i_r[g] <= rl[g][2] ? i_r[g] + 10'd1 : 10'd0;
      if (!rl[g][3]) j_r[g] <= rl[g][4] ? j_r[g] + 10'd1 : 10'd0;
      if (!rl[g][8]) k_r[g] <= rl[g][9] ? k_r[g] + 11'd1 : 11'd0;
      if (!rl[g][12])
        min_r[g] <= rl[g][13] ? mo[g] + a_mem[g][oa_r[g][1:0]] * b_mem[g][ob_r[g][1:0]] : 26'd0;
      if (rl[g][16])     ao_r[g] <= ao_r[g] - 11'd1;
      else if (!rl[g][5]) ao_r[g] <= 11'(i_r[g]) + 11'(j_r[g]);
      if (!rl[g][10]) oa_r[g] <= i_r[g];
      if (!rl[g][11]) ob_r[g] <= j_r[g];
      if (!rl[g][6]) ai_r[g] <= rl[g][7] ? 11'(i_r[g]) + 11'(j_r[g]) : k_r[g];
      if (!rl[g][15]) deg_r[g] <= ao_r[g] + 11'd1;
      we_r[g] <= rl[g][14];
      if (we_r[g] && ai_r[g] < 11'd7) c_mem[g][ai_r[g][2:0]] <= min_r[g];
      pipe[g][0] <= (ao_r[g] < 11'd7) ? c_mem[g][ao_r[g][2:0]] : 26'd0;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  typedef struct packed {
    logic [6:0][25:0] c;
    logic [10:0]      deg;
    logic [15:0]      lat;
  } exp_t;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  localparam logic [16:1] HOLD_CODE = (16'd1 << 0) | (16'd1 << 2) | (16'd1 << 4) | (16'd1 << 5)
                                    | (16'd1 << 7) | (16'd1 << 9) | (16'd1 << 10) | (16'd1 << 11)
                                    | (16'd1 << 14);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input int g);
    exp_t e;
    int   top;
    int   lat;
    e = '0;
    for (int x = 0; x < TN; x++)
      for (int y = 0; y < TN; y++)
        e.c[x + y] = e.c[x + y] + a_mem[g][x] * b_mem[g][y];
    top = 0;
    for (int n = 0; n < 7; n++)
      if (e.c[n] != 26'd0) top = n;
    lat = (g == 0) ? 1 : 3;
    e.deg = 11'(top + 1);
    e.lat = 16'(1 + 2 * 7 + 1 + TN * TN * (lat + 4) + 1 + (7 - top) * (lat + 1) + 1);
    return e;
  endfunction

  task automatic run(input int g, input bit chk_clr);
    exp_t e;
    int   cyc;
    int   nwr;
    sb.push_back(predict(g));
    @(negedge clk);
    start_v[g] = 1'b1;
    cyc = 0;
    nwr = 0;
    do begin
      @(negedge clk);
      cyc++;
      start_v[g] = 1'b0;
      if (cyc == 1) check_eq("busy_in_run", 32'(busy_v[g]), 32'd1);
      if (chk_clr && cyc <= 16 && we_r[g]) begin
        check_eq("clr_addr", 32'(ai_r[g]), 32'(nwr));
        check_eq("clr_data", 32'(min_r[g]), 32'd0);
        nwr++;
      end
    end while (!done_v[g] && cyc < 400);
    e = sb.pop_front();
    check_eq("done_seen", 32'(done_v[g]), 32'd1);
    check_eq("latency", 32'(cyc), 32'(e.lat));
    check_eq("deg", 32'(deg_r[g]), 32'(e.deg));
    for (int n = 0; n < 7; n++) check_eq($sformatf("c[%0d]", n), 32'(c_mem[g][n]), 32'(e.c[n]));
    if (chk_clr) check_eq("clr_count", 32'(nwr), 32'd7);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done_v[g]), 32'd0);
    check_eq("busy_after", 32'(busy_v[g]), 32'd0);
  endtask

  task automatic set_ops(input int g, input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
    a_mem[g][0] = 26'(a0); a_mem[g][1] = 26'(a1); a_mem[g][2] = 26'(a2); a_mem[g][3] = 26'(a3);
    b_mem[g][0] = 26'(b0); b_mem[g][1] = 26'(b1); b_mem[g][2] = 26'(b2); b_mem[g][3] = 26'(b3);
  endtask

  initial begin
    int  found;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_ops(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check_eq("idle_hold", 32'(rl[g]), 32'(HOLD_CODE));
        check_eq("idle_busy", 32'(busy_v[g]), 32'd0);
        check_eq("idle_done", 32'(done_v[g]), 32'd0);
        check_eq("idle_we", 32'(we_r[g]), 32'd0);
      end
    end

    set_ops(0, 1, 2, 0, 0, 3, 0, 0, 5);
    run(0, 1'b1);
    check_eq("example_deg", 32'(deg_r[0]), 32'd5);
    check_eq("example_c4", 32'(c_mem[0][4]), 32'd10);

    set_ops(0, 0, 0, 0, 0, 7, 1, 9, 4);
    run(0, 1'b0);
    check_eq("zero_deg", 32'(deg_r[0]), 32'd1);

    set_ops(1, 1, 2, 0, 0, 3, 0, 0, 5);
    run(1, 1'b0);

    set_ops(0, 1, 2, 3, 4, 5, 6, 7, 8);
    @(negedge clk);
    start_v[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 200 && found == 0; t++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (!rl[0][12] && rl[0][13]) found = 1;
    end
    check_eq("reached_mac", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_hold", 32'(rl[0]), 32'(HOLD_CODE));
    check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check_eq("abort_we", 32'(we_r[0]), 32'd0);
      check_eq("abort_idle", 32'(busy_v[0]), 32'd0);
    end

    set_ops(0, $urandom_range(0, 999), $urandom_range(0, 999), $urandom_range(0, 999),
            $urandom_range(1, 999), $urandom_range(0, 999), $urandom_range(0, 999),
            $urandom_range(0, 999), $urandom_range(0, 999));
    run(0, 1'b1);
    set_ops(1, 0, $urandom_range(1, 999), 0, 0, $urandom_range(1, 999), 0, 0, 0);
    run(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
